// File: rtl/lcd_pkg.sv
// Shared types and constants for the Spartan-3E 4-bit HD44780 LCD path:
// writer state encoding, default bus timing and command bytes.
package lcd_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HI_SETUP,
        HI_PULSE,
        HI_HOLD,
        GAP,
        LO_SETUP,
        LO_PULSE,
        LO_HOLD,
        SETTLE
    } lcdState_t;

    // Default timing in 50 MHz clock cycles
    localparam int LCD_CLK_SETUP    = 2;
    localparam int LCD_CLK_PULSE    = 12;
    localparam int LCD_CLK_HOLD     = 1;
    localparam int LCD_CLK_GAP      = 50;
    localparam int LCD_CLK_WAIT     = 2000;
    localparam int LCD_CLK_LONGWAIT = 82000;
    localparam int LCD_CNT_W        = 17;

    // HD44780 command bytes; Clear and Home need the long settle
    localparam logic [7:0] LCD_CMD_CLEAR        = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME         = 8'h02;
    localparam logic [7:0] LCD_CMD_ENTRY_MODE   = 8'h06;
    localparam logic [7:0] LCD_CMD_DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] LCD_CMD_DISPLAY_OFF  = 8'h08;
    localparam logic [7:0] LCD_CMD_FUNCSET_4BIT = 8'h28;
    localparam logic [7:0] LCD_CMD_SET_DDRAM    = 8'h80;

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that sets the dwell of each writer state.
// oDone is high while the count is zero.
module lcd_delay_counter #(
    parameter int CNT_W = 17
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iLoad,
    input  logic [CNT_W-1:0] iLoadValue,
    output logic             oDone
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (iLoad) begin
            count <= iLoadValue;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign oDone = (count == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// Writes one byte to the 4-bit LCD bus as two enable-strobed nibbles,
// then holds off further requests for the controller's execution time.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int CLK_SETUP    = LCD_CLK_SETUP,
    parameter int CLK_PULSE    = LCD_CLK_PULSE,
    parameter int CLK_HOLD     = LCD_CLK_HOLD,
    parameter int CLK_GAP      = LCD_CLK_GAP,
    parameter int CLK_WAIT     = LCD_CLK_WAIT,
    parameter int CLK_LONGWAIT = LCD_CLK_LONGWAIT,
    parameter int CNT_W        = LCD_CNT_W
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iValid,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iLongWait,
    output logic       oReady,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_StrataFlashControl,
    output logic       oLCD_ReadWrite,
    output logic [3:0] oLCD_Data,
    output lcdState_t  oState
);

    // Handshake: a byte is taken on any rising edge where iValid and oReady
    // are both 1; iValid while oReady is 0 is dropped, never queued.

    if (CLK_SETUP < 1 || CLK_PULSE < 1 || CLK_HOLD < 1 || CLK_GAP < 1 ||
        CLK_WAIT < 1 || CLK_LONGWAIT < 1) begin : gBadDwell
        $error("lcd_byte_writer: every dwell parameter must be at least 1");
    end
    if (longint'(CLK_LONGWAIT) > (longint'(1) << CNT_W) ||
        longint'(CLK_WAIT) > (longint'(1) << CNT_W)) begin : gBadWidth
        $error("lcd_byte_writer: CNT_W too narrow for the settle dwell");
    end

    localparam logic [CNT_W-1:0] SETUP_M1 = CNT_W'(CLK_SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_M1 = CNT_W'(CLK_PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_M1  = CNT_W'(CLK_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'(CLK_GAP - 1);
    localparam logic [CNT_W-1:0] WAIT_M1  = CNT_W'(CLK_WAIT - 1);
    localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(CLK_LONGWAIT - 1);

    lcdState_t        state;
    lcdState_t        nextState;
    logic [3:0]       loNibbleReg;
    logic             longWaitReg;
    logic [3:0]       nextData;
    logic             nextRs;
    logic             cntLoad;
    logic [CNT_W-1:0] cntLoadValue;
    logic             cntDone;
    logic             accept;

    assign accept = (state == IDLE) && iValid;

    lcd_delay_counter #(.CNT_W(CNT_W)) uDelay (
        .Clock      (Clock),
        .Reset      (Reset),
        .iLoad      (cntLoad),
        .iLoadValue (cntLoadValue),
        .oDone      (cntDone)
    );

    always_comb begin
        nextState = state;
        nextData  = oLCD_Data;
        nextRs    = oLCD_RegisterSelect;
        case (state)
            IDLE: begin
                if (iValid) begin
                    nextState = HI_SETUP;
                    nextData  = iData[7:4];
                    nextRs    = iRS;
                end
            end
            HI_SETUP: if (cntDone) nextState = HI_PULSE;
            HI_PULSE: if (cntDone) nextState = HI_HOLD;
            HI_HOLD:  if (cntDone) nextState = GAP;
            GAP: begin
                if (cntDone) begin
                    nextState = LO_SETUP;
                    nextData  = loNibbleReg;
                end
            end
            LO_SETUP: if (cntDone) nextState = LO_PULSE;
            LO_PULSE: if (cntDone) nextState = LO_HOLD;
            LO_HOLD:  if (cntDone) nextState = SETTLE;
            SETTLE:   if (cntDone) nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    // Counter is reloaded with (dwell - 1) on entry to every timed state
    always_comb begin
        cntLoad      = (nextState != state) && (nextState != IDLE);
        cntLoadValue = '0;
        case (nextState)
            HI_SETUP, LO_SETUP: cntLoadValue = SETUP_M1;
            HI_PULSE, LO_PULSE: cntLoadValue = PULSE_M1;
            HI_HOLD, LO_HOLD:   cntLoadValue = HOLD_M1;
            GAP:                cntLoadValue = GAP_M1;
            SETTLE:             cntLoadValue = longWaitReg ? LONG_M1 : WAIT_M1;
            default:            cntLoadValue = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state               <= IDLE;
            oReady              <= 1'b1;
            oLCD_Enabled        <= 1'b0;
            oLCD_RegisterSelect <= 1'b0;
            oLCD_Data           <= 4'h0;
            loNibbleReg         <= 4'h0;
            longWaitReg         <= 1'b0;
        end else begin
            state               <= nextState;
            oReady              <= (nextState == IDLE);
            oLCD_Enabled        <= (nextState == HI_PULSE) || (nextState == LO_PULSE);
            oLCD_RegisterSelect <= nextRs;
            oLCD_Data           <= nextData;
            if (accept) begin
                loNibbleReg <= iData[3:0];
                longWaitReg <= iLongWait;
            end
        end
    end

    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_ReadWrite          = 1'b0;
    assign oState                  = state;

endmodule

// File: doc/lcd_byte_writer.md
Name: lcd_byte_writer

Overview:
- Downstream of the MiniAlu `LCD` instruction path. Accepts one byte (command or character) per handshake.
- Sends it to the Spartan-3E 4-bit LCD bus as a high nibble then a low nibble, with HD44780 setup, enable-pulse, hold and settle timing.
- Sits between the ALU and the LCD pins. The power-on init sequencer will drive this block through the same request port.

Parameters:
- CLK_SETUP, 2, cycles RS/data are stable before Enable rises (≥40 ns @50 MHz).
- CLK_PULSE, 12, cycles Enable stays high (≥230 ns).
- CLK_HOLD, 1, cycles data/RS are held after Enable falls.
- CLK_GAP, 50, idle cycles between high and low nibble (1 µs).
- CLK_WAIT, 2000, settle cycles after the low nibble for normal commands and data (40 µs).
- CLK_LONGWAIT, 82000, settle cycles after the low nibble when iLongWait is set (1.64 ms, Clear/Home).
- CNT_W, 17, width of the delay counter; must hold CLK_LONGWAIT.

Ports:
- Clock, input, 1, system clock.
- Reset, input, 1, synchronous, active-high.
- iValid, input, 1, write request.
- iData, input, 8, byte to send.
- iRS, input, 1, register select: 0 = command, 1 = data.
- iLongWait, input, 1, use CLK_LONGWAIT instead of CLK_WAIT.
- oReady, output, 1, block idle; a request is accepted this cycle.
- oLCD_Enabled, output, 1, LCD E.
- oLCD_RegisterSelect, output, 1, LCD RS.
- oLCD_StrataFlashControl, output, 1, tied 1 (StrataFlash disabled).
- oLCD_ReadWrite, output, 1, tied 0 (write only).
- oLCD_Data, output, 4, LCD DB7..DB4.

Behaviour:
- Clock and reset: one clock, Clock; reset is synchronous and active-high on Reset.
- Reset values:
  - state IDLE, oReady=1, oLCD_Enabled=0, oLCD_RegisterSelect=0, oLCD_Data=0.
  - oLCD_StrataFlashControl=1 and oLCD_ReadWrite=0 at all times.
- Accept: at a rising edge with iValid=1 and oReady=1, iData, iRS and iLongWait are latched into internal registers. oReady goes 0 from the next cycle. iValid while oReady=0 is ignored (no queueing).
- States and dwell, all registered outputs:
  - HI_SETUP, CLK_SETUP cycles: Data=byte[7:4], RS=latched RS, E=0.
  - HI_PULSE, CLK_PULSE cycles: E=1.
  - HI_HOLD, CLK_HOLD cycles: E=0, Data/RS unchanged.
  - GAP, CLK_GAP cycles: E=0, Data unchanged.
  - LO_SETUP, LO_PULSE, LO_HOLD: same dwells as the high nibble, with Data=byte[3:0].
  - SETTLE, CLK_WAIT or CLK_LONGWAIT cycles.
  - Then IDLE, with oReady=1.
- Busy time: accept edge to oReady=1 is SETUP+PULSE+HOLD+GAP+SETUP+PULSE+HOLD+WAIT cycles. Default: 2080.
- Output stability: Data and RS change only on HI_SETUP or LO_SETUP entry. They never change while E=1. In IDLE they hold their last values.
- Delay counter:
  - Loaded with (dwell−1) on state entry and decremented each cycle; the state advances when it reaches 0.
  - A dwell parameter of 0 is illegal; assert in simulation.
- Back-to-back: a new request may be accepted in the same cycle oReady first reads 1. The next HI_SETUP follows immediately, with no extra bubble.
- Reset mid-operation: on the next edge, abort to IDLE with E=0 and oReady=1. The partial byte is lost; the LCD recovers via the upstream re-init.
- Simultaneous Reset and iValid: Reset wins and nothing is latched.

Decomposition:
- Shared package lcd_pkg:
  - state enum: IDLE, HI_SETUP, HI_PULSE, HI_HOLD, GAP, LO_SETUP, LO_PULSE, LO_HOLD, SETTLE.
  - default timing constants.
  - HD44780 command byte constants for the init sequencer and ALU use.
- One sub-module: lcd_delay_counter, a loadable down-counter with a done flag, CNT_W wide.

Test Plan:
All scenarios use SETUP=1, PULSE=2, HOLD=1, GAP=3, WAIT=5, LONGWAIT=9 (busy=16, long=20).
- Reset, then idle: oReady=1, E=0, Data=0, RS=0, RW=0, SF=1 for 10 cycles.
- Send iData=8'hA5, iRS=1 →
  - Data=4'hA with E=1 for 2 cycles starting 1 cycle after accept.
  - Then Data=4'h5 with E=1 for 2 cycles.
  - RS=1 throughout; oReady=1 exactly 16 cycles after accept.
- Send 8'h01, iRS=0, iLongWait=1 → two E pulses (Data 0 then 1); oReady returns after 20 cycles.
- Hold iValid high with 8'h41 then 8'h42 → second accepted on the first oReady=1 cycle; second HI_SETUP begins the next cycle; exactly 4 E pulses total.
- iValid pulse during busy → ignored; E pulse count stays 2.
- Assert Reset during HI_PULSE → next cycle E=0, oReady=1; a following 8'h33 request completes normally.
